// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, defaults and state type for the BCD/binary converters
package bcd_pkg;

  localparam int DIGITS_DEF = 4;
  localparam int BIN_W_DEF  = 16;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

endpackage

// File: rtl/bcd_binary_if.sv
// rtl/bcd_binary_if.sv - start/valid handshake bundle between a requester and the BCD-to-binary converter
interface bcd_binary_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
);

  logic                  start;
  logic [4*DIGITS-1:0]   BCD_code;
  logic                  busy;
  logic                  valid;
  logic                  error;
  logic [BIN_W-1:0]      bin_result;

  modport master (
    output start, BCD_code,
    input  busy, valid, error, bin_result
  );

  modport slave (
    input  start, BCD_code,
    output busy, valid, error, bin_result
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - one-nibble reverse double-dabble correction (>=8 subtract 3)
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? (din - BCD_ADJ_VAL) : din;

endmodule

// File: rtl/bcd_binary.sv
// rtl/bcd_binary.sv - iterative packed-BCD to unsigned binary converter, one shift per clock
module bcd_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
)(
  input  logic         clk,
  input  logic         reset,
  bcd_binary_if.slave  bus
);

  localparam int SCR_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  state_t             state_q, state_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [BIN_W-1:0]   binreg_q, binreg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               valid_q, valid_d;
  logic               error_q, error_d;
  logic [BIN_W-1:0]   result_q, result_d;

  logic [SCR_W+BIN_W-1:0] shifted;
  logic [SCR_W-1:0]       shifted_scr;
  logic [SCR_W-1:0]       adjusted_scr;
  logic [BIN_W-1:0]       shifted_bin;
  logic                   bad_digit;

  assign shifted     = {scratch_q, binreg_q} >> 1;
  assign shifted_scr = shifted[SCR_W+BIN_W-1 -: SCR_W];
  assign shifted_bin = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (shifted_scr[4*g +: 4]),
      .dout (adjusted_scr[4*g +: 4])
    );
  end

  // Operand is validated from the captured copy so BCD_code may change after the start edge.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] > BCD_MAX_DIGIT) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    scratch_d = scratch_q;
    binreg_d  = binreg_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    error_d   = error_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          scratch_d = bus.BCD_code;
          binreg_d  = '0;
          cnt_d     = '0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (cnt_q == '0 && bad_digit) begin
          valid_d  = 1'b1;
          error_d  = 1'b1;
          result_d = '0;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          scratch_d = adjusted_scr;
          binreg_d  = shifted_bin;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            result_d = shifted_bin;
            valid_d  = 1'b1;
            error_d  = 1'b0;
            busy_d   = 1'b0;
            state_d  = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      scratch_q <= '0;
      binreg_q  <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      binreg_q  <= binreg_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      result_q  <= result_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.valid      = valid_q;
  assign bus.error      = error_q;
  assign bus.bin_result = result_q;

endmodule

// File: tb/tb_bcd_binary.sv
// tb/tb_bcd_binary.sv - directed self-checking bench for bcd_binary with a cycle-level reference model
module tb_bcd_binary;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 16;

  logic clk = 1'b0;
  logic reset;

  bcd_binary_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic logic [15:0] bin2bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference model: decimal decode of the operand, completion scheduled by cycle number.
  bit          m_live = 0;
  bit          m_pending = 0;
  bit          m_valid = 0;
  bit          m_bad = 0;
  bit          m_err = 0;
  int          m_cyc = 0;
  int          m_due = 0;
  int          m_val = 0;
  logic [15:0] m_res = '0;

  always @(posedge clk) begin
    m_valid = 0;
    if (reset) begin
      m_live    = 1;
      m_pending = 0;
      m_res     = '0;
      m_err     = 0;
      m_cyc     = 0;
    end else begin
      m_cyc++;
      if (m_pending && m_cyc == m_due) begin
        m_pending = 0;
        m_valid   = 1;
        m_err     = m_bad;
        m_res     = m_bad ? 16'd0 : 16'(m_val);
      end else if (!m_pending && bus.start === 1'b1) begin
        m_val = 0;
        m_bad = 0;
        for (int i = 3; i >= 0; i--) begin
          int d;
          d = int'((bus.BCD_code >> (4*i)) & 16'hF);
          if (d > 9) m_bad = 1;
          m_val = m_val * 10 + d;
        end
        m_pending = 1;
        m_err     = 0;
        m_due     = m_cyc + (m_bad ? 1 : BIN_W);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_busy",   32'(bus.busy),       32'(m_pending));
      check("model_valid",  32'(bus.valid),      32'(m_valid));
      check("model_error",  32'(bus.error),      32'(m_err));
      check("model_result", 32'(bus.bin_result), 32'(m_res));
    end
  end

  task automatic launch(input logic [15:0] code);
    bus.start    = 1'b1;
    bus.BCD_code = code;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.BCD_code = 16'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.valid !== 1'b1 && lat < 40);
    if (bus.valid !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL valid_timeout: no valid within %0d cycles", lat);
    end
  endtask

  task automatic conv(input string name, input logic [15:0] code, input int exp_val,
                      input bit exp_err, input int exp_lat);
    int lat;
    launch(code);
    wait_valid(lat);
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_val"}, 32'(bus.bin_result), 32'(exp_val));
    check({name, "_err"}, 32'(bus.error), 32'(exp_err));
    if (!exp_err) check({name, "_rt"}, 32'(bin2bcd(int'(bus.bin_result))), 32'(code));
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int stray;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.BCD_code = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(bus.busy),       32'd0);
    check("rst_valid",  32'(bus.valid),      32'd0);
    check("rst_error",  32'(bus.error),      32'd0);
    check("rst_result", 32'(bus.bin_result), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First conversion, also counting busy cycles before valid.
    launch(16'h0045);
    busy_cnt = 1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.busy === 1'b1) busy_cnt++;
    end while (bus.valid !== 1'b1 && lat < 40);
    check("c45_lat",  32'(lat),            32'd16);
    check("c45_busy", 32'(busy_cnt),       32'd16);
    check("c45_val",  32'(bus.bin_result), 32'd45);
    check("c45_err",  32'(bus.error),      32'd0);
    @(negedge clk);
    check("c45_pulse", 32'(bus.valid), 32'd0);
    check("c45_hold",  32'(bus.bin_result), 32'd45);

    conv("c123",  16'h0123, 123,  0, 16);
    conv("c999",  16'h0999, 999,  0, 16);
    conv("c2047", 16'h2047, 2047, 0, 16);
    conv("c256",  16'h0256, 256,  0, 16);
    conv("c9999", 16'h9999, 16'h270F, 0, 16);

    // Invalid digit then an immediate legal start during the error-valid cycle.
    conv("bad",  16'h12A4, 0, 1, 1);
    conv("c7",   16'h0007, 7, 0, 16);

    // Start while busy is ignored.
    @(negedge clk);
    launch(16'h0050);
    repeat (4) @(negedge clk);
    launch(16'h0077);
    wait_valid(lat);
    check("ign_lat", 32'(lat), 32'd11);
    check("ign_val", 32'(bus.bin_result), 32'd50);
    conv("b2b33", 16'h0033, 33, 0, 16);

    // Reset mid-conversion aborts without a valid pulse.
    @(negedge clk);
    launch(16'h4321);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",   32'(bus.busy),       32'd0);
    check("abort_result", 32'(bus.bin_result), 32'd0);
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.valid !== 1'b0) stray++;
    end
    check("abort_no_valid", 32'(stray), 32'd0);
    conv("c0", 16'h0000, 0, 0, 16);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
